// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus RISC datapath: a Moore FSM that walks
// fetch (T0-T2) and execute (T3-T7) steps and decodes every datapath strobe from the state.
module control_sequencer #(
   parameter logic [2:0] MEM_WAIT = 3'd0
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR,
   input  logic        ConOtp,
   input  logic        stop,
   output logic        PCout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        BAout,
   output logic        Cout,
   output logic        Rout,
   output logic        MARin,
   output logic        Zin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        Rin,
   output logic        CONin,
   output logic        OutportIn,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Read,
   output logic        Write,
   output logic [4:0]  ALU_Control,
   output logic        run
);

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
   } state_t;

   localparam logic [4:0] OP_LD   = 5'd0;
   localparam logic [4:0] OP_LDI  = 5'd1;
   localparam logic [4:0] OP_ST   = 5'd2;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_ADDI = 5'd12;
   localparam logic [4:0] OP_BR   = 5'd19;
   localparam logic [4:0] OP_JR   = 5'd20;
   localparam logic [4:0] OP_OUT  = 5'd23;
   localparam logic [4:0] OP_HALT = 5'd27;

   localparam logic [4:0] ALU_ADD = 5'd2;
   localparam logic [4:0] ALU_SUB = 5'd3;
   localparam logic [4:0] ALU_AND = 5'd4;
   localparam logic [4:0] ALU_OR  = 5'd5;
   localparam logic [4:0] ALU_INC = 5'd12;

   state_t     state;
   logic [4:0] op;
   logic [2:0] wait_cnt;
   logic       is_arith;
   logic       is_imm;
   logic       is_mem;
   logic       unused_ir;

   assign unused_ir = ^IR[26:0];
   assign is_arith  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   assign is_imm    = (op == OP_ADDI) || (op == OP_LDI);
   assign is_mem    = (op == OP_LD) || (op == OP_ST);

   // State, latched opcode and memory-wait counter. Every return to T0 is an
   // instruction boundary, where a pending stop diverts to PAUSE instead.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= S_RESET;
         op       <= 5'd0;
         wait_cnt <= 3'd0;
      end else begin
         case (state)
            S_RESET: state <= stop ? S_PAUSE : S_T0;
            S_PAUSE: if (!stop) state <= S_T0;
            S_T0: begin
               state    <= S_T1;
               wait_cnt <= MEM_WAIT;
            end
            S_T1: begin
               if (wait_cnt == 3'd0) state <= S_T2;
               else                  wait_cnt <= wait_cnt - 3'd1;
            end
            S_T2: begin
               op <= IR[31:27];
               case (IR[31:27])
                  OP_HALT: state <= S_HALT;
                  OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
                  OP_ADDI, OP_BR, OP_JR, OP_OUT: state <= S_T3;
                  default: state <= stop ? S_PAUSE : S_T0;
               endcase
            end
            S_T3: begin
               if (op == OP_JR || op == OP_OUT) state <= stop ? S_PAUSE : S_T0;
               else                             state <= S_T4;
            end
            S_T4: state <= S_T5;
            S_T5: begin
               if (is_mem || op == OP_BR) begin
                  state    <= S_T6;
                  wait_cnt <= MEM_WAIT;
               end else begin
                  state <= stop ? S_PAUSE : S_T0;
               end
            end
            S_T6: begin
               if (op == OP_LD) begin
                  if (wait_cnt == 3'd0) state <= S_T7;
                  else                  wait_cnt <= wait_cnt - 3'd1;
               end else if (op == OP_ST) begin
                  state    <= S_T7;
                  wait_cnt <= MEM_WAIT;
               end else begin
                  state <= stop ? S_PAUSE : S_T0;
               end
            end
            S_T7: begin
               if (op == OP_ST && wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
               else                                 state    <= stop ? S_PAUSE : S_T0;
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_RESET;
         endcase
      end
   end

   // Strobe decode from the present state; the PC update in fetch happens only
   // on the first T1 cycle, recognised by the counter still holding MEM_WAIT.
   always_comb begin
      {PCout, Zlowout, MDRout, BAout, Cout, Rout} = 6'b0;
      {MARin, Zin, PCin, MDRin, IRin, Yin, Rin, CONin, OutportIn} = 9'b0;
      {Gra, Grb, Grc, Read, Write} = 5'b0;
      ALU_Control = 5'd0;
      run = 1'b0;
      case (state)
         S_T0: begin
            run = 1'b1; PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; ALU_Control = ALU_INC;
         end
         S_T1: begin
            run = 1'b1; Read = 1'b1; MDRin = 1'b1;
            if (wait_cnt == MEM_WAIT) begin
               Zlowout = 1'b1; PCin = 1'b1;
            end
         end
         S_T2: begin
            run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
         end
         S_T3: begin
            run = 1'b1;
            if (is_arith) begin
               Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
            end else if (is_imm || is_mem) begin
               Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
            end else if (op == OP_BR) begin
               Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
            end else if (op == OP_JR) begin
               Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
            end else if (op == OP_OUT) begin
               Gra = 1'b1; Rout = 1'b1; OutportIn = 1'b1;
            end
         end
         S_T4: begin
            run = 1'b1;
            if (is_arith) begin
               Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
               case (op)
                  OP_SUB:  ALU_Control = ALU_SUB;
                  OP_AND:  ALU_Control = ALU_AND;
                  OP_OR:   ALU_Control = ALU_OR;
                  default: ALU_Control = ALU_ADD;
               endcase
            end else if (is_imm || is_mem) begin
               Cout = 1'b1; Zin = 1'b1; ALU_Control = ALU_ADD;
            end else if (op == OP_BR) begin
               PCout = 1'b1; Yin = 1'b1;
            end
         end
         S_T5: begin
            run = 1'b1;
            if (is_arith || is_imm) begin
               Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (is_mem) begin
               Zlowout = 1'b1; MARin = 1'b1;
            end else if (op == OP_BR) begin
               Cout = 1'b1; Zin = 1'b1; ALU_Control = ALU_ADD;
            end
         end
         S_T6: begin
            run = 1'b1;
            if (op == OP_LD) begin
               Read = 1'b1; MDRin = 1'b1;
            end else if (op == OP_ST) begin
               Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
            end else if (op == OP_BR && ConOtp) begin
               Zlowout = 1'b1; PCin = 1'b1;
            end
         end
         S_T7: begin
            run = 1'b1;
            if (op == OP_LD) begin
               MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (op == OP_ST) begin
               Write = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: three instances (MEM_WAIT 0/1/2) share stimulus,
// and each scenario compares the selected instance's strobes cycle by cycle.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] IR;
   logic        ConOtp;
   logic        stop;
   int          sel;
   int          total = 0;
   int          bad = 0;

   // Strobe vector bit positions: bus drivers, loads, selects, memory, run.
   localparam logic [20:0] PCO  = 21'd1 << 0;
   localparam logic [20:0] ZLO  = 21'd1 << 1;
   localparam logic [20:0] MDRO = 21'd1 << 2;
   localparam logic [20:0] BAO  = 21'd1 << 3;
   localparam logic [20:0] CO   = 21'd1 << 4;
   localparam logic [20:0] RO   = 21'd1 << 5;
   localparam logic [20:0] MARI = 21'd1 << 6;
   localparam logic [20:0] ZI   = 21'd1 << 7;
   localparam logic [20:0] PCI  = 21'd1 << 8;
   localparam logic [20:0] MDRI = 21'd1 << 9;
   localparam logic [20:0] IRI  = 21'd1 << 10;
   localparam logic [20:0] YI   = 21'd1 << 11;
   localparam logic [20:0] RI   = 21'd1 << 12;
   localparam logic [20:0] CONI = 21'd1 << 13;
   localparam logic [20:0] OUTI = 21'd1 << 14;
   localparam logic [20:0] GA   = 21'd1 << 15;
   localparam logic [20:0] GB   = 21'd1 << 16;
   localparam logic [20:0] GC   = 21'd1 << 17;
   localparam logic [20:0] RD   = 21'd1 << 18;
   localparam logic [20:0] WR   = 21'd1 << 19;
   localparam logic [20:0] RUN  = 21'd1 << 20;

   localparam logic [20:0] FT0  = PCO | MARI | ZI | RUN;
   localparam logic [20:0] FT1A = RD | MDRI | ZLO | PCI | RUN;
   localparam logic [20:0] FT1B = RD | MDRI | RUN;
   localparam logic [20:0] FT2  = MDRO | IRI | RUN;

   localparam logic [31:0] IR_ADD  = 32'h18A40000;
   localparam logic [31:0] IR_BR   = 32'h9B180019;
   localparam logic [31:0] IR_ST   = 32'h10800010;
   localparam logic [31:0] IR_LD   = 32'h00800010;
   localparam logic [31:0] IR_NOP  = 32'hD0000000;
   localparam logic [31:0] IR_HALT = 32'hD8000000;

   logic [20:0] s0, s1, s2, ctl;
   logic [4:0]  a0, a1, a2, alu;

   control_sequencer #(.MEM_WAIT(3'd0)) dut0 (
      .clk(clk), .clr(clr), .IR(IR), .ConOtp(ConOtp), .stop(stop),
      .PCout(s0[0]), .Zlowout(s0[1]), .MDRout(s0[2]), .BAout(s0[3]), .Cout(s0[4]), .Rout(s0[5]),
      .MARin(s0[6]), .Zin(s0[7]), .PCin(s0[8]), .MDRin(s0[9]), .IRin(s0[10]), .Yin(s0[11]),
      .Rin(s0[12]), .CONin(s0[13]), .OutportIn(s0[14]), .Gra(s0[15]), .Grb(s0[16]), .Grc(s0[17]),
      .Read(s0[18]), .Write(s0[19]), .ALU_Control(a0), .run(s0[20]));

   control_sequencer #(.MEM_WAIT(3'd1)) dut1 (
      .clk(clk), .clr(clr), .IR(IR), .ConOtp(ConOtp), .stop(stop),
      .PCout(s1[0]), .Zlowout(s1[1]), .MDRout(s1[2]), .BAout(s1[3]), .Cout(s1[4]), .Rout(s1[5]),
      .MARin(s1[6]), .Zin(s1[7]), .PCin(s1[8]), .MDRin(s1[9]), .IRin(s1[10]), .Yin(s1[11]),
      .Rin(s1[12]), .CONin(s1[13]), .OutportIn(s1[14]), .Gra(s1[15]), .Grb(s1[16]), .Grc(s1[17]),
      .Read(s1[18]), .Write(s1[19]), .ALU_Control(a1), .run(s1[20]));

   control_sequencer #(.MEM_WAIT(3'd2)) dut2 (
      .clk(clk), .clr(clr), .IR(IR), .ConOtp(ConOtp), .stop(stop),
      .PCout(s2[0]), .Zlowout(s2[1]), .MDRout(s2[2]), .BAout(s2[3]), .Cout(s2[4]), .Rout(s2[5]),
      .MARin(s2[6]), .Zin(s2[7]), .PCin(s2[8]), .MDRin(s2[9]), .IRin(s2[10]), .Yin(s2[11]),
      .Rin(s2[12]), .CONin(s2[13]), .OutportIn(s2[14]), .Gra(s2[15]), .Grb(s2[16]), .Grc(s2[17]),
      .Read(s2[18]), .Write(s2[19]), .ALU_Control(a2), .run(s2[20]));

   always #5 clk = ~clk;

   always_comb begin
      ctl = s0;
      alu = a0;
      if (sel == 1) begin
         ctl = s1;
         alu = a1;
      end else if (sel == 2) begin
         ctl = s2;
         alu = a2;
      end
   end

   // Holds clr low through one falling edge, then releases it so the next rising edge enters T0.
   task automatic apply_reset(input logic [31:0] ir_val, input int which);
      sel    = which;
      IR     = ir_val;
      ConOtp = 1'b0;
      stop   = 1'b0;
      clr    = 1'b0;
      @(negedge clk);
      clr = 1'b1;
   endtask

   task automatic test_reset();
      logic [20:0] ev [5];
      logic [4:0]  ea [5];
      ev = '{FT0, FT1A, FT2, GB | RO | YI | RUN, GC | RO | ZI | RUN};
      ea = '{5'd12, 5'd0, 5'd0, 5'd0, 5'd2};
      sel = 0; IR = IR_ADD; ConOtp = 1'b0; stop = 1'b0; clr = 1'b0;
      @(negedge clk);
      total++;
      if (ctl !== 21'd0 || alu !== 5'd0) begin
         bad++;
         $display("[TB] FAIL reset_idle: got %h/%0d want 0/0", ctl, alu);
      end
      clr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (ctl !== ev[i] || alu !== ea[i]) begin
            bad++;
            $display("[TB] FAIL reset_seq[%0d]: got %h/%0d want %h/%0d", i, ctl, alu, ev[i], ea[i]);
         end
      end
      clr = 1'b0;
      #1;
      total++;
      if (ctl !== 21'd0 || alu !== 5'd0) begin
         bad++;
         $display("[TB] FAIL reset_mid_t4: got %h/%0d want 0/0", ctl, alu);
      end
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      total++;
      if (ctl !== FT0 || alu !== 5'd12) begin
         bad++;
         $display("[TB] FAIL reset_release_t0: got %h/%0d want %h/12", ctl, alu, FT0);
      end
   endtask

   task automatic test_add();
      logic [20:0] ev [7];
      logic [4:0]  ea [7];
      ev = '{FT0, FT1A, FT2, GB | RO | YI | RUN, GC | RO | ZI | RUN, ZLO | GA | RI | RUN, FT0};
      ea = '{5'd12, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd12};
      apply_reset(IR_ADD, 0);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         total++;
         if (ctl !== ev[i] || alu !== ea[i]) begin
            bad++;
            $display("[TB] FAIL add[%0d]: got %h/%0d want %h/%0d", i, ctl, alu, ev[i], ea[i]);
         end
      end
   endtask

   task automatic test_fetch_wait();
      logic [20:0] ev [6];
      logic [4:0]  ea [6];
      ev = '{FT0, FT1A, FT1B, FT1B, FT2, FT0};
      ea = '{5'd12, 5'd0, 5'd0, 5'd0, 5'd0, 5'd12};
      apply_reset(IR_NOP, 2);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if (ctl !== ev[i] || alu !== ea[i]) begin
            bad++;
            $display("[TB] FAIL fetch_wait[%0d]: got %h/%0d want %h/%0d", i, ctl, alu, ev[i], ea[i]);
         end
      end
   endtask

   task automatic test_branch();
      logic [20:0] ev [8];
      logic [4:0]  ea [8];
      for (int pass = 0; pass < 2; pass++) begin
         ev = '{FT0, FT1A, FT2, GA | RO | CONI | RUN, PCO | YI | RUN, CO | ZI | RUN,
                (pass == 0) ? (ZLO | PCI | RUN) : RUN, FT0};
         ea = '{5'd12, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd12};
         apply_reset(IR_BR, 0);
         ConOtp = (pass == 0);
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (ctl !== ev[i] || alu !== ea[i]) begin
               bad++;
               $display("[TB] FAIL br_con%0d[%0d]: got %h/%0d want %h/%0d",
                        1 - pass, i, ctl, alu, ev[i], ea[i]);
            end
         end
      end
   endtask

   task automatic test_ld_st();
      logic [20:0] ev [11];
      ev = '{FT0, FT1A, FT1B, FT2, GB | BAO | YI | RUN, CO | ZI | RUN, ZLO | MARI | RUN,
             GA | RO | MDRI | RUN, WR | RUN, WR | RUN, FT0};
      apply_reset(IR_ST, 1);
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         total++;
         if (ctl !== ev[i]) begin
            bad++;
            $display("[TB] FAIL st[%0d]: got %h want %h", i, ctl, ev[i]);
         end
      end
      ev = '{FT0, FT1A, FT1B, FT2, GB | BAO | YI | RUN, CO | ZI | RUN, ZLO | MARI | RUN,
             RD | MDRI | RUN, RD | MDRI | RUN, MDRO | GA | RI | RUN, FT0};
      apply_reset(IR_LD, 1);
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         total++;
         if (ctl !== ev[i]) begin
            bad++;
            $display("[TB] FAIL ld[%0d]: got %h want %h", i, ctl, ev[i]);
         end
      end
   endtask

   task automatic test_stop_halt();
      logic [20:0] ev [6];
      apply_reset(IR_ADD, 0);
      repeat (5) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      total++;
      if (ctl !== (ZLO | GA | RI | RUN)) begin
         bad++;
         $display("[TB] FAIL stop_t5: got %h want %h", ctl, ZLO | GA | RI | RUN);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (ctl !== 21'd0 || alu !== 5'd0) begin
            bad++;
            $display("[TB] FAIL pause[%0d]: got %h/%0d want 0/0", i, ctl, alu);
         end
      end
      stop = 1'b0;
      IR   = IR_HALT;
      ev = '{FT0, FT1A, FT2, 21'd0, 21'd0, 21'd0};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if (ctl !== ev[i]) begin
            bad++;
            $display("[TB] FAIL halt[%0d]: got %h want %h", i, ctl, ev[i]);
         end
      end
   endtask

   initial begin
      sel = 0; IR = 32'd0; ConOtp = 1'b0; stop = 1'b0; clr = 1'b0;
      test_reset();
      test_add();
      test_fetch_wait();
      test_branch();
      test_ld_st();
      test_stop_halt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
